mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single CPU-side memory port of the MMIO/SRAM front end (valid/ready/addr/dtw/dtr/rw) between NREQ requesters, e.g. instruction fetch, load/store unit and a DMA engine. Each transaction is registered, forwarded unmodified and completed with a one-cycle ready pulse to its requester. A watchdog aborts transactions the downstream port never acknowledges.

## Interface
- NREQ, 2: number of requesters, 2..8.
- TIMEOUT, 255: cycles to wait for mrdy before aborting; 0 disables the watchdog.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request strobe per requester; held until its req_ready pulse.
- req_ready  out  NREQ  one-cycle completion pulse, one-hot or zero.
- req_addr  in  32*NREQ  flattened addresses; requester i at [32i+31:32i].
- req_dtw  in  32*NREQ  flattened write data.
- req_rw  in  NREQ  1 = write, 0 = read.
- req_dtr  out  32  read data; valid only while some req_ready bit is 1.
- req_err  out  1  high with req_ready when the transaction timed out.
- mval  out  1  downstream valid (to mmio valid).
- mrdy  in  1  downstream ready (from mmio ready).
- maddr, mdtw  out  32  downstream address and write data.
- mdtr  in  32  downstream read data.
- mrw  out  1  downstream direction.
- gnt  out  NREQ  one-hot grant; zero in IDLE.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY, RESP (2-bit encoding).
- IDLE: if any req_valid, pick winner g as the first set bit searching ptr, ptr+1, …, wrapping mod NREQ. Latch req_addr[g], req_dtw[g] and req_rw[g] into maddr, mdtw and mrw. Set gnt = 1<<g and mval = 1, clear the watchdog, then go to BUSY.
- BUSY: mval is held high and the latched fields are stable.
  - On the edge where mrdy = 1: mval <= 0; req_ready[g] <= 1; req_dtr <= mdtr; req_err <= 0; go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT (with TIMEOUT != 0): mval <= 0; req_ready[g] <= 1; req_dtr <= 32'hFFFF_FFFF; req_err <= 1; go to RESP.
  - mrdy takes priority over timeout in the same cycle.
- RESP: req_ready, req_err and gnt clear on the next edge; ptr <= (g+1) mod NREQ; go to IDLE.
- Requesters deassert req_valid on the edge they sample req_ready. The RESP cycle guarantees a stale request is never re-granted.
- A requester that drops req_valid mid-transaction is ignored: the transaction completes and the ready pulse is still issued.
- The request fields of non-granted requesters are never sampled.
- mdtr is captured for writes too; requesters ignore req_dtr on writes.
- Watchdog width is $clog2(TIMEOUT+1), saturating.

## Timing
- All outputs are registered. Reset values: mval 0, maddr/mdtw 0, mrw 0, req_ready 0, req_dtr 0, req_err 0, gnt 0, busy 0, ptr 0, state IDLE.
- Minimum latency is 3 cycles from req_valid sampled to req_ready high: IDLE edge, BUSY with mrdy already high, RESP.
- Throughput is one transaction per 3 cycles plus downstream wait states.
- Back-to-back requesters alternate in strict rotation; worst-case wait is (NREQ-1) transactions.
- A reset assertion mid-transaction drops mval and all outputs immediately. The downstream side treats the transaction as abandoned.

## Structure
- Shared header/package: state encodings (ARB_IDLE, ARB_BUSY, ARB_RESP), DATA_W = 32 and the abort pattern 32'hFFFF_FFFF.
- Sub-module rr_pick: combinational round-robin picker, (req[NREQ], ptr) -> one-hot grant plus index. Instantiated once.

## Test plan
- Single read: NREQ=2, req_valid=01, addr 0x100, mrdy high immediately, mdtr 0xDEADBEEF -> mval high 1 cycle, maddr 0x100, req_ready=01 on the 3rd cycle, req_dtr 0xDEADBEEF, req_err 0.
- Contention: both valid continuously for 4 transactions -> grant order 0,1,0,1; each req_ready one cycle; no requester serviced twice in a row.
- Wait states: mrdy held low 5 cycles, write, dtw 0x12345678 -> mval, maddr, mdtw and mrw=1 stable throughout; req_ready 1 cycle after the mrdy edge.
- Timeout: TIMEOUT=4, mrdy never high -> mval drops after 4 BUSY cycles; req_ready with req_err=1 and req_dtr 0xFFFFFFFF; arbiter returns to IDLE and serves the next request.
- Reset mid-BUSY: assert reset asynchronously -> mval, gnt and busy drop within the same cycle; after release, ptr=0 and requester 0 wins a simultaneous request.
- Pointer wrap: NREQ=3, only requester 2 then requester 0 valid -> ptr wraps 2->0; requester 0 granted next without an idle gap beyond RESP.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the round-robin memory-port arbiter:
//               arbiter state encoding, data width, abort read pattern, the
//               per-requester transaction record and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Width of the CPU-side memory port (address, write data, read data).
    localparam int DATA_W = 32;

    // Read data returned to a requester whose transaction was aborted.
    localparam logic [DATA_W-1:0] ABORT_DATA = 32'hFFFF_FFFF;

    // Arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Fields a requester presents with its request; forwarded unmodified.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] dtw;
        logic              rw;
    } mem_req_t;

    // Width of a requester index; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width. A disabled watchdog (timeout 0) still gets a
    // one-bit counter so that no zero-width vectors are ever declared.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches the request
//               vector starting at index ptr and wrapping modulo NREQ; the
//               first set bit wins.
// Ports       : req  [NREQ]  - request vector
//               ptr  [IDX_W] - index searched first (highest priority)
//               gnt  [NREQ]  - one-hot winner, zero when no request
//               idx  [IDX_W] - binary index of the winner
//               any          - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr + offset (at most 2*NREQ-2) never overflows
    // before the modulo-NREQ wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        // Walk from the farthest offset down to offset 0: every hit
        // overwrites the previous one, so the candidate nearest to ptr
        // is the one left standing.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NREQ)) begin
                sum = sum - (IDX_W + 1)'(NREQ);
            end
            pos = sum[IDX_W-1:0];
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
                any      = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one CPU-side memory port among
//               NREQ requesters. Each granted transaction is latched,
//               forwarded unmodified downstream and completed with a
//               one-cycle ready pulse to its requester. A watchdog aborts a
//               transaction that the downstream port never acknowledges.
// Parameters  : NREQ    - number of requesters (2..8)
//               TIMEOUT - BUSY cycles without mrdy before abort; 0 disables
// Ports       : clk, reset (async, active high)
//               req_valid/req_rw [NREQ], req_addr/req_dtw [32*NREQ] - in
//               req_ready [NREQ], req_dtr [32], req_err               - out
//               mval, maddr, mdtw, mrw (out) / mrdy, mdtr (in)  - downstream
//               gnt [NREQ] one-hot grant, busy = not idle              - out
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,

    // Requester side
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_dtw,
    input  logic [NREQ-1:0]        req_rw,
    output logic [DATA_W-1:0]      req_dtr,
    output logic                   req_err,

    // Downstream memory port
    output logic                   mval,
    input  logic                   mrdy,
    output logic [DATA_W-1:0]      maddr,
    output logic [DATA_W-1:0]      mdtw,
    input  logic [DATA_W-1:0]      mdtr,
    output logic                   mrw,

    // Status
    output logic [NREQ-1:0]        gnt,
    output logic                   busy
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int WD_W  = wd_width(TIMEOUT);

    // ------------------------------------------------------------------
    // Per-requester view of the flattened request buses
    // ------------------------------------------------------------------
    mem_req_t req_fields [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign req_fields[i] = {req_addr[DATA_W*i +: DATA_W],
                                    req_dtw[DATA_W*i +: DATA_W],
                                    req_rw[i]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       state;
    logic [IDX_W-1:0] ptr;   // requester searched first at the next grant
    logic [IDX_W-1:0] cur;   // requester owning the current transaction
    logic [WD_W-1:0]  wd;    // BUSY cycles spent without mrdy

    // ------------------------------------------------------------------
    // Round-robin choice among the currently valid requesters
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    mem_req_t         pick_fields;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the winner's fields are ever looked at.
    assign pick_fields = req_fields[pick_idx];

    // ------------------------------------------------------------------
    // Pointer advance: the requester after the one just served
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ptr_next;

    assign ptr_next = (cur == IDX_W'(NREQ - 1)) ? '0 : cur + 1'b1;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic [WD_W-1:0] wd_inc;
    logic            timeout_hit;

    // Saturating so a wide counter can never wrap back to a small value.
    assign wd_inc = (wd == '1) ? wd : wd + 1'b1;

    generate
        if (TIMEOUT != 0) begin : g_wd_on
            // Abort on the BUSY edge at which the count would reach TIMEOUT,
            // i.e. after exactly TIMEOUT BUSY cycles without mrdy.
            assign timeout_hit = (wd_inc == WD_W'(TIMEOUT));
        end else begin : g_wd_off
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            cur       <= '0;
            wd        <= '0;
            mval      <= 1'b0;
            maddr     <= '0;
            mdtw      <= '0;
            mrw       <= 1'b0;
            gnt       <= '0;
            req_ready <= '0;
            req_dtr   <= '0;
            req_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        maddr <= pick_fields.addr;
                        mdtw  <= pick_fields.dtw;
                        mrw   <= pick_fields.rw;
                        gnt   <= pick_gnt;
                        cur   <= pick_idx;
                        mval  <= 1'b1;
                        wd    <= '0;
                        busy  <= 1'b1;
                        state <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    // mrdy wins over a watchdog expiry in the same cycle.
                    if (mrdy) begin
                        mval      <= 1'b0;
                        req_ready <= gnt;
                        req_dtr   <= mdtr;
                        req_err   <= 1'b0;
                        state     <= ARB_RESP;
                    end else if (timeout_hit) begin
                        mval      <= 1'b0;
                        req_ready <= gnt;
                        req_dtr   <= ABORT_DATA;
                        req_err   <= 1'b1;
                        state     <= ARB_RESP;
                    end else begin
                        wd <= wd_inc;
                    end
                end

                ARB_RESP: begin
                    // One dead cycle lets the served requester drop its
                    // valid before the next grant decision is taken.
                    req_ready <= '0;
                    req_err   <= 1'b0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    ptr       <= ptr_next;
                    state     <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (NREQ=3, TIMEOUT=6).
//               A cycle-level reference model predicts every output from the
//               arbitration rules; a table of single transactions, several
//               hand-written corner sequences and a randomized phase drive it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N   = 3;
    localparam int TO  = 6;
    localparam int PER = 10;

    logic               clk;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [32*N-1:0]    req_addr;
    logic [32*N-1:0]    req_dtw;
    logic [N-1:0]       req_rw;
    logic [31:0]        req_dtr;
    logic               req_err;
    logic               mval;
    logic               mrdy;
    logic [31:0]        maddr;
    logic [31:0]        mdtw;
    logic [31:0]        mdtr;
    logic               mrw;
    logic [N-1:0]       gnt;
    logic               busy;

    logic [31:0]        addr_a [N];
    logic [31:0]        dtw_a  [N];

    int n_cmp = 0;
    int n_bad = 0;

    always_comb begin
        req_addr = '0;
        req_dtw  = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = addr_a[i];
            req_dtw[32*i +: 32]  = dtw_a[i];
        end
    end

    mem_arbiter #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_dtw   (req_dtw),
        .req_rw    (req_rw),
        .req_dtr   (req_dtr),
        .req_err   (req_err),
        .mval      (mval),
        .mrdy      (mrdy),
        .maddr     (maddr),
        .mdtw      (mdtw),
        .mdtr      (mdtr),
        .mrw       (mrw),
        .gnt       (gnt),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #(PER/2) clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within the cycle budget, expected one (t=%0t)", nm, $time);
    endtask

    // First valid requester searching from p upward, wrapping modulo N.
    function automatic int rr(input logic [N-1:0] v, input int p);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: inputs are captured at each rising edge, the
    // predicted register contents after that edge are compared at the
    // following falling edge.
    // ------------------------------------------------------------------
    initial begin : model
        logic [N-1:0] v_c;
        logic [N-1:0] rw_c;
        logic [31:0]  a_c [N];
        logic [31:0]  d_c [N];
        logic         rdy_c;
        logic         live_c;
        logic [31:0]  mdtr_c;
        int           ph;      // 0 waiting for a request, 1 downstream pending, 2 response cycle
        int           mptr;
        int           g;
        int           waits;
        logic [31:0]  e_addr, e_dtw, e_dtr;
        logic         e_rw, e_mval, e_err, e_busy;
        logic [N-1:0] e_gnt, e_rdy;

        ph = 0; mptr = 0; g = 0; waits = 0;
        e_addr = '0; e_dtw = '0; e_dtr = '0; e_rw = 1'b0;
        e_mval = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_gnt = '0; e_rdy = '0;
        forever begin
            @(posedge clk);
            v_c    = req_valid;
            rw_c   = req_rw;
            rdy_c  = mrdy;
            mdtr_c = mdtr;
            live_c = !reset;
            for (int i = 0; i < N; i++) begin
                a_c[i] = addr_a[i];
                d_c[i] = dtw_a[i];
            end
            @(negedge clk);
            if (reset || !live_c) begin
                ph = 0; mptr = 0;
                e_addr = '0; e_dtw = '0; e_dtr = '0; e_rw = 1'b0;
                e_mval = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_gnt = '0; e_rdy = '0;
            end else begin
                case (ph)
                    0: begin
                        if (v_c != '0) begin
                            g      = rr(v_c, mptr);
                            e_addr = a_c[g];
                            e_dtw  = d_c[g];
                            e_rw   = rw_c[g];
                            e_gnt  = N'(1) << g;
                            e_mval = 1'b1;
                            e_busy = 1'b1;
                            waits  = 0;
                            ph     = 1;
                        end
                    end
                    1: begin
                        if (rdy_c) begin
                            e_mval = 1'b0;
                            e_rdy  = e_gnt;
                            e_dtr  = mdtr_c;
                            e_err  = 1'b0;
                            ph     = 2;
                        end else begin
                            waits++;
                            if (TO != 0 && waits >= TO) begin
                                e_mval = 1'b0;
                                e_rdy  = e_gnt;
                                e_dtr  = 32'hFFFF_FFFF;
                                e_err  = 1'b1;
                                ph     = 2;
                            end
                        end
                    end
                    default: begin
                        e_rdy  = '0;
                        e_err  = 1'b0;
                        e_gnt  = '0;
                        e_busy = 1'b0;
                        mptr   = (g + 1) % N;
                        ph     = 0;
                    end
                endcase
            end
            chk("m_mval",  32'(mval),      32'(e_mval));
            chk("m_gnt",   32'(gnt),       32'(e_gnt));
            chk("m_ready", 32'(req_ready), 32'(e_rdy));
            chk("m_err",   32'(req_err),   32'(e_err));
            chk("m_busy",  32'(busy),      32'(e_busy));
            chk("m_maddr", maddr,          e_addr);
            chk("m_mdtw",  mdtw,           e_dtw);
            chk("m_mrw",   32'(mrw),       32'(e_rw));
            if (e_rdy != '0 || reset || !live_c) chk("m_dtr", req_dtr, e_dtr);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        logic [N-1:0] valid;
        logic [31:0]  base;     // requester i presents base + 4*i
        logic [31:0]  dtw;      // requester i presents dtw ^ i
        logic         rw;
        int           wait_c;   // BUSY edges with mrdy low; >= TO means never
        logic [31:0]  din;
        int           exp_g;
        logic         exp_err;
        logic [31:0]  exp_dtr;
    } vec_t;

    initial begin : stim
        vec_t         tab [8];
        logic         found;
        time          t_g;
        int           lat;
        int           cnt;
        logic [N-1:0] order [4];
        logic [N-1:0] rs;

        // Pointer starts at 0 after reset; each row's winner follows from
        // the rotation left by the previous row.
        tab[0] = '{3'b001, 32'h0000_0100, 32'h0000_0000, 1'b0, 0,  32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF};
        tab[1] = '{3'b011, 32'h0000_0200, 32'hA5A5_0000, 1'b0, 2,  32'h1111_2222, 1, 1'b0, 32'h1111_2222};
        tab[2] = '{3'b011, 32'h0000_0300, 32'h0F0F_0000, 1'b1, 0,  32'h3333_4444, 0, 1'b0, 32'h3333_4444};
        tab[3] = '{3'b101, 32'h0000_0400, 32'h1234_5678, 1'b1, 5,  32'h5555_6666, 2, 1'b0, 32'h5555_6666};
        tab[4] = '{3'b110, 32'h0000_0500, 32'hCAFE_0000, 1'b0, 99, 32'h7777_8888, 1, 1'b1, 32'hFFFF_FFFF};
        tab[5] = '{3'b111, 32'h0000_0600, 32'hBEEF_0000, 1'b0, 1,  32'h9999_AAAA, 2, 1'b0, 32'h9999_AAAA};
        tab[6] = '{3'b100, 32'h0000_0700, 32'h0000_0070, 1'b1, 0,  32'hBBBB_CCCC, 2, 1'b0, 32'hBBBB_CCCC};
        tab[7] = '{3'b001, 32'h0000_0800, 32'h0000_0080, 1'b0, 0,  32'hDDDD_EEEE, 0, 1'b0, 32'hDDDD_EEEE};

        reset     = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        mrdy      = 1'b0;
        mdtr      = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            dtw_a[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mval",  32'(mval),      32'd0);
        chk("rst_maddr", maddr,          32'd0);
        chk("rst_mdtw",  mdtw,           32'd0);
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_dtr",   req_dtr,        32'd0);
        chk("rst_err",   32'(req_err),   32'd0);

        // Table of single transactions
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                addr_a[i] = tab[t].base + 32'(i * 4);
                dtw_a[i]  = tab[t].dtw ^ 32'(i);
            end
            req_rw    = {N{tab[t].rw}};
            req_valid = tab[t].valid;
            mrdy      = 1'b0;
            mdtr      = $urandom;
            found     = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (gnt != '0) begin found = 1'b1; break; end
            end
            if (!found) begin
                fail_bound("tab_grant");
            end else begin
                t_g = $time;
                chk("tab_gnt",   32'(gnt),  32'(N'(1) << tab[t].exp_g));
                chk("tab_maddr", maddr,     tab[t].base + 32'(tab[t].exp_g * 4));
                chk("tab_mdtw",  mdtw,      tab[t].dtw ^ 32'(tab[t].exp_g));
                chk("tab_mrw",   32'(mrw),  32'(tab[t].rw));
                mdtr = tab[t].din;
                if (tab[t].wait_c == 0) begin
                    mrdy = 1'b1;
                end else if (tab[t].wait_c < TO) begin
                    repeat (tab[t].wait_c) @(posedge clk);
                    #1 mrdy = 1'b1;
                end
                found = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (req_ready != '0) begin found = 1'b1; break; end
                end
                if (!found) begin
                    fail_bound("tab_ready");
                end else begin
                    lat = int'(($time - t_g) / PER);
                    chk("tab_ready", 32'(req_ready), 32'(N'(1) << tab[t].exp_g));
                    chk("tab_dtr",   req_dtr,        tab[t].exp_dtr);
                    chk("tab_err",   32'(req_err),   32'(tab[t].exp_err));
                    chk("tab_lat",   32'(lat),       32'((tab[t].wait_c < TO) ? tab[t].wait_c + 1 : TO));
                end
            end
            @(posedge clk); #1;
            req_valid = '0;
            mrdy      = 1'b0;
        end

        // Contention: requesters 0 and 1 valid continuously after a reset
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < N; i++) addr_a[i] = 32'h0000_1000 + 32'(i * 16);
        req_rw    = '0;
        req_valid = 3'b011;
        mrdy      = 1'b1;
        cnt       = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready != '0 && cnt < 4) begin
                order[cnt] = req_ready;
                cnt++;
            end
            if (cnt == 4) break;
        end
        if (cnt < 4) begin
            fail_bound("cont_ready");
        end else begin
            chk("cont_0", 32'(order[0]), 32'b001);
            chk("cont_1", 32'(order[1]), 32'b010);
            chk("cont_2", 32'(order[2]), 32'b001);
            chk("cont_3", 32'(order[3]), 32'b010);
        end
        @(posedge clk); #1;
        req_valid = '0;
        mrdy      = 1'b0;
        repeat (2) @(posedge clk);

        // Requester 0 drops valid mid-transaction; its ready still arrives
        #1 req_valid = 3'b001;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gnt != '0) begin found = 1'b1; break; end
        end
        if (!found) fail_bound("drop_grant");
        else chk("drop_gnt", 32'(gnt), 32'b001);
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 mrdy = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin found = 1'b1; break; end
        end
        if (!found) begin
            fail_bound("drop_ready");
        end else begin
            chk("drop_ready", 32'(req_ready), 32'b001);
            chk("drop_err",   32'(req_err),   32'd0);
        end
        @(posedge clk); #1 mrdy = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a pending transaction
        #1 req_valid = 3'b010;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gnt != '0) begin found = 1'b1; break; end
        end
        if (!found) fail_bound("rstb_grant");
        else chk("rstb_gnt", 32'(gnt), 32'b010);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rstb_mval", 32'(mval), 32'd0);
        chk("rstb_gnt0", 32'(gnt),  32'd0);
        chk("rstb_busy", 32'(busy), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
        req_valid = 3'b111;
        mrdy      = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gnt != '0) begin found = 1'b1; break; end
        end
        if (!found) fail_bound("rsta_grant");
        else chk("rsta_gnt", 32'(gnt), 32'b001);
        @(posedge clk); #1;
        req_valid = '0;
        mrdy      = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized traffic with random downstream wait states
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rs = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    addr_a[i]    = $urandom;
                    dtw_a[i]     = $urandom;
                    req_rw[i]    = 1'($urandom_range(0, 1));
                    req_valid[i] = 1'b1;
                end
            end
            mrdy = ($urandom_range(0, 9) < 3);
            mdtr = $urandom;
        end
        @(posedge clk); #1;
        req_valid = '0;
        mrdy      = 1'b0;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
